// File: rtl/riscv_pkg.sv
// Shared RV32I-subset definitions: opcodes, controller states, ALU codes and datapath select codes.
// Pure declarations; no latency, no flow control.
package riscv_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BEQ
    } state_e;

    // ALU operation codes, shared with the ALU itself
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps (aluop, funct3, op[5], funct7[5]) to the 3-bit ALU operation; shared with the single-cycle core.
// Purely combinational, zero latency; no flow control.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       op_b5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // Only R-type can subtract; addi has op[5]=0 and its funct7 bits are immediate
                    3'b000:  alu_control_o = (op_b5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multicycle RV32I core: issues datapath enables/selects per state.
// Outputs combinational from state (pc_write also from zero in BEQ); no handshakes, never stalls.
module multicycle_control_unit
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal_op
);

    state_e     state_q, state_d;
    state_e     decode_target;
    logic       op_legal;
    logic [1:0] aluop;
    logic       pc_update;
    logic       branch;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       mem_write_raw;
    logic       illegal_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction decoder: where DECODE goes for each opcode
    always_comb begin
        decode_target = S_FETCH;
        op_legal      = 1'b1;
        case (op)
            OP_LW, OP_SW: decode_target = S_MEMADR;
            OP_R:         decode_target = S_EXECUTER;
            OP_I:         decode_target = S_EXECUTEI;
            OP_JAL:       decode_target = S_JAL;
            OP_BEQ:       decode_target = S_BEQ;
            default: begin
                decode_target = S_FETCH;
                op_legal      = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE:   state_d = decode_target;
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        adr_src       = ADR_PC;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        aluop         = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                adr_src      = ADR_PC;
                ir_write_raw = 1'b1;
                alu_src_a    = SRCA_PC;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
                pc_update    = 1'b1;
            end
            S_DECODE: begin
                // Speculative branch target lands in ALUOut for a possible BEQ
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_IMM;
                illegal_raw = !op_legal;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                result_src = RES_ALUOUT;
                adr_src    = ADR_ALUOUT;
            end
            S_MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                result_src    = RES_ALUOUT;
                adr_src       = ADR_ALUOUT;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                aluop     = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                aluop     = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                result_src    = RES_ALUOUT;
                reg_write_raw = 1'b1;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_update  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                aluop      = ALUOP_SUB;
                result_src = RES_ALUOUT;
                branch     = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop_i      (aluop),
        .funct3_i     (funct3),
        .op_b5_i      (op[5]),
        .funct7b5_i   (funct7b5),
        .alu_control_o(alu_control)
    );

    assign imm_src = imm_src_of(op);

    // Enables are masked directly by reset so nothing commits during the asynchronous assertion
    assign pc_write   = rst & (pc_update | (branch & zero));
    assign ir_write   = rst & ir_write_raw;
    assign reg_write  = rst & reg_write_raw;
    assign mem_write  = rst & mem_write_raw;
    assign illegal_op = rst & illegal_raw;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized instruction stream against a per-instruction cycle-by-cycle expectation model,
// plus directed instructions pinned with hand-computed values.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    multicycle_control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .alu_control(alu_control),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
        logic       illegal_op;
    } outs_t;

    outs_t act;
    outs_t exp_o = '0;
    outs_t obs [8];
    logic  chk = 1'b0;
    logic  mask_imm = 1'b0;
    int    cur_k = 0;
    int    checks = 0;
    int    failures = 0;

    assign act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                  alu_src_a, alu_src_b, imm_src, alu_control, illegal_op};

    function automatic logic legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
    endfunction

    function automatic int ilen(input logic [6:0] o);
        case (o)
            7'b0000011: return 5;
            7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
            7'b1100011: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] alu_fn(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // What the controller must show in cycle k of an instruction with these fields
    function automatic outs_t model(input logic [6:0] o, input logic [2:0] f3,
                                    input logic f7, input logic z, input int k);
        outs_t e;
        e = '0;
        e.imm_src = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 :
                    (o == 7'b1101111) ? 2'b11 : 2'b00;
        if (k == 0) begin
            e.ir_write = 1'b1; e.pc_write = 1'b1;
            e.alu_src_b = 2'b10; e.result_src = 2'b10;
        end else if (k == 1) begin
            e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
            e.illegal_op = !legal(o);
        end else begin
            case (o)
                7'b0000011: begin
                    if (k == 2) begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
                    if (k == 3) e.adr_src = 1'b1;
                    if (k == 4) begin e.result_src = 2'b01; e.reg_write = 1'b1; end
                end
                7'b0100011: begin
                    if (k == 2) begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
                    if (k == 3) begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
                end
                7'b0110011: begin
                    if (k == 2) begin e.alu_src_a = 2'b10; e.alu_control = alu_fn(f3, f7); end
                    if (k == 3) e.reg_write = 1'b1;
                end
                7'b0010011: begin
                    if (k == 2) begin
                        e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_control = alu_fn(f3, 1'b0);
                    end
                    if (k == 3) e.reg_write = 1'b1;
                end
                7'b1101111: begin
                    if (k == 2) begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
                    if (k == 3) e.reg_write = 1'b1;
                end
                7'b1100011: begin
                    e.alu_src_a = 2'b10; e.alu_control = 3'b001; e.pc_write = z;
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    function automatic outs_t reset_exp();
        outs_t e;
        e = '0;
        e.alu_src_b = 2'b10;
        e.result_src = 2'b10;
        return e;
    endfunction

    task automatic cmp(input string name, input outs_t a, input outs_t e, input logic mi);
        outs_t am, em;
        am = a; em = e;
        if (mi) begin am.imm_src = 2'b00; em.imm_src = 2'b00; end
        checks++;
        if (am !== em) begin
            failures++;
            $display("FAIL %s k=%0d op=%b f3=%b f7b5=%b actual=%h expected=%h",
                     name, cur_k, op, funct3, funct7b5, am, em);
        end
    endtask

    task automatic lit(input string name, input logic [3:0] a, input logic [3:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            cmp("cycle", act, exp_o, mask_imm);
            obs[cur_k] = act;
        end
    end

    // Caller is #1 after the edge that entered FETCH; returns in the next FETCH cycle
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zsel, input int abort_at);
        int n;
        n = ilen(o);
        for (int k = 0; k < n; k++) begin
            if (k != 0) begin @(posedge clk); #1; end
            if (k == 0) begin op = o; funct3 = f3; funct7b5 = f7; end
            zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            cur_k = k;
            exp_o = model(o, f3, f7, zero, k);
            mask_imm = (k == 0);
            chk = 1'b1;
            if (k == abort_at) begin
                @(negedge clk); #1;
                rst = 1'b0;
                exp_o = reset_exp();
                mask_imm = 1'b1;
                #1;
                cmp("reset_mid_immediate", act, reset_exp(), 1'b1);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b1;
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [6:0] ro;
        int         sel;
        int         n;
        int         ab;
        exp_o = reset_exp();
        mask_imm = 1'b1;
        chk = 1'b1;
        repeat (3) @(posedge clk);
        lit("reset_ir_write", 4'(ir_write), 4'd0);
        lit("reset_pc_write", 4'(pc_write), 4'd0);
        #1;
        rst = 1'b1;

        // lw x5,8(x0)
        run_instr(7'b0000011, 3'b010, 1'b0, -1, -1);
        lit("release_ir_write", 4'(obs[0].ir_write), 4'd1);
        lit("release_pc_write", 4'(obs[0].pc_write), 4'd1);
        lit("release_alu_src_b", 4'(obs[0].alu_src_b), 4'd2);
        lit("lw_regwrite_c4", 4'(obs[3].reg_write), 4'd0);
        lit("lw_regwrite_c5", 4'(obs[4].reg_write), 4'd1);
        lit("lw_result_src_c5", 4'(obs[4].result_src), 4'd1);

        run_instr(7'b0100011, 3'b010, 1'b0, -1, -1);
        lit("sw_memwrite_c3", 4'(obs[2].mem_write), 4'd0);
        lit("sw_memwrite_c4", 4'(obs[3].mem_write), 4'd1);
        lit("sw_adr_src_c4", 4'(obs[3].adr_src), 4'd1);
        lit("sw_imm_src", 4'(obs[2].imm_src), 4'd1);

        run_instr(7'b0110011, 3'b000, 1'b1, -1, -1);
        lit("r_sub", 4'(obs[2].alu_control), 4'd1);
        run_instr(7'b0110011, 3'b000, 1'b0, -1, -1);
        lit("r_add", 4'(obs[2].alu_control), 4'd0);
        run_instr(7'b0110011, 3'b010, 1'b0, -1, -1);
        lit("r_slt", 4'(obs[2].alu_control), 4'd5);
        run_instr(7'b0110011, 3'b110, 1'b0, -1, -1);
        lit("r_or", 4'(obs[2].alu_control), 4'd3);
        run_instr(7'b0110011, 3'b111, 1'b0, -1, -1);
        lit("r_and", 4'(obs[2].alu_control), 4'd2);

        run_instr(7'b1100011, 3'b000, 1'b0, 1, -1);
        lit("beq_taken_pc_write", 4'(obs[2].pc_write), 4'd1);
        lit("beq_taken_refetch", 4'(ir_write), 4'd1);
        run_instr(7'b1100011, 3'b000, 1'b0, 0, -1);
        lit("beq_not_taken_pc_write", 4'(obs[2].pc_write), 4'd0);
        lit("beq_not_taken_refetch", 4'(ir_write), 4'd1);

        run_instr(7'b1111111, 3'b000, 1'b0, -1, -1);
        lit("illegal_pulse", 4'(obs[1].illegal_op), 4'd1);
        lit("illegal_no_write", 4'({obs[1].reg_write, obs[1].mem_write, obs[1].pc_write}), 4'd0);
        lit("illegal_refetch", 4'(ir_write), 4'd1);

        // Reset during MEMREAD of a lw: no write-back may follow
        run_instr(7'b0000011, 3'b010, 1'b0, -1, 3);
        lit("mid_reset_regwrite", 4'(obs[3].reg_write), 4'd0);
        run_instr(7'b0010011, 3'b000, 1'b1, -1, -1);
        lit("addi_no_sub", 4'(obs[2].alu_control), 4'd0);

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 6);
            case (sel)
                0: ro = 7'b0000011;
                1: ro = 7'b0100011;
                2: ro = 7'b0110011;
                3: ro = 7'b0010011;
                4: ro = 7'b1101111;
                5: ro = 7'b1100011;
                default: ro = 7'($urandom);
            endcase
            n = ilen(ro);
            ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, n - 1) : -1;
            run_instr(ro, 3'($urandom), 1'($urandom), -1, ab);
        end

        chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
